uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised buffered UART transmitter. A synchronous FIFO accepts words from the host side, and a serializer frames each word with a start bit, data LSB-first, optional parity and 1 or 2 stop bits. Bit timing comes from an external one-cycle baud tick. It is the next-generation TX path, adding configurable width, depth, parity, stop bits, occupancy and overflow reporting.

Parameters:
DATA_W, 8, data bits per frame (5..9)
DEPTH, 8, FIFO entries; power of 2, >= 2
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_D  in  DATA_W  write data
i_write  in  1  write strobe, one word per cycle
i_baud  in  1  baud tick, one-cycle pulse per bit period
o_full  out  1  FIFO holds DEPTH words
o_empty  out  1  FIFO holds 0 words
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_busy  out  1  serializer is in a frame (state != IDLE)
o_overflow  out  1  one-cycle pulse when a write is dropped
o_tx  out  1  serial line, idle high

Behaviour:
- Reset (async, i_rst=0): o_tx=1, o_full=0, o_empty=1, o_count=0, o_busy=0, o_overflow=0. Pointers are cleared and the FIFO is flushed. Reset mid-frame aborts the frame and o_tx goes high immediately.
- FIFO pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full means the MSBs differ and the remaining bits are equal. Empty means the pointers are equal.
- o_full, o_empty and o_count are registered and reflect the state after the previous edge.
- Write accepted iff i_write && !o_full. The word becomes visible (o_empty=0, o_count+1) on the next cycle.
- Write while o_full: the word is dropped and o_overflow=1 on the next cycle. This holds even if a pop occurs in the same cycle.
- Pop and accepted write in the same cycle: o_count is unchanged.
- Serializer FSM states: IDLE, START, DATA, PAR, STOP. All transitions occur only on cycles with i_baud=1.
  - IDLE: o_tx=1. On i_baud && !o_empty, pop the head word into the shift register and go to START.
  - START: o_tx=0. On i_baud, go to DATA with bit index 0.
  - DATA: o_tx = shift[0]. On i_baud, shift right and increment the index. After bit DATA_W-1, go to PAR if PARITY!=0, else STOP.
  - PAR: o_tx = ^data for even parity, ~^data for odd parity. On i_baud, go to STOP.
  - STOP: o_tx=1 for STOP_BITS baud periods. On the final i_baud, if !o_empty, pop and go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- o_tx is registered and changes the cycle after the i_baud edge that causes the transition. Each bit lasts exactly one baud period.
- Latency: a write at cycle t is poppable from t+1. o_tx falls the cycle after the first i_baud at or after t+1.
- The serializer holds its own copy of the word, so a FIFO write into the popped slot never corrupts the frame in flight.
- i_baud asserted on consecutive cycles is legal: each pulse advances one bit.

Decomposition:
- Package uart_pkg holds:
  - parity_e (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e (IDLE, START, DATA, PAR, STOP)
  - IDLE_LEVEL constant = 1'b1
- Sub-module uart_tx_serializer (FSM, shift register, bit and stop counters, parity) with a pop/valid handshake to the FIFO.
- The FIFO stays inline in uart_tx_fifo.

Test Plan:
- Defaults, write 0xA5 once, i_baud every 16 cycles -> o_tx per baud period 0,1,0,1,0,0,1,0,1,1, then idle 1. o_busy is high for exactly 10 periods.
- PARITY=2, write 0x07 -> parity bit 1. PARITY=1, same data -> parity bit 0. Frame is 11 periods long.
- No i_baud, 8 writes 0x01..0x08 -> o_count=8, o_full=1. 9th write 0xFF -> o_overflow pulses once, o_count stays 8. Enabling baud drains 0x01..0x08 in order with no 0xFF.
- Two words queued, STOP_BITS=2 -> second start bit immediately follows the second stop period, with no extra idle period.
- FIFO full; write on the same cycle the serializer pops -> write dropped, o_overflow=1, o_count=7.
- Assert i_rst during DATA bit 3 -> o_tx=1 and o_empty=1 asynchronously. After release, a new write transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write port, baud tick and status/serial outputs.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]      i_D;
    logic                   i_write;
    logic                   i_baud;
    logic                   o_full;
    logic                   o_empty;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_busy;
    logic                   o_overflow;
    logic                   o_tx;
    modport slave (input i_D, i_write, i_baud, output o_full, o_empty, o_count, o_busy, o_overflow, o_tx);
    modport master (output i_D, i_write, i_baud, input o_full, o_empty, o_count, o_busy, o_overflow, o_tx);
endinterface

// File: rtl/uart_tx_fifo_serializer.sv
// uart_tx_serializer: frames one word as start, LSB-first data, optional parity, stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_baud,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_pop,
    output logic              o_busy,
    output logic              o_tx
);
    localparam int IW = $clog2(DATA_W);
    tx_state_e         state;
    logic [DATA_W-1:0] shift, word;
    logic [IW-1:0]     idx;
    logic              stop_cnt, last_stop, par_bit;
    assign last_stop = state == STOP && stop_cnt == 1'(STOP_BITS - 1);
    assign o_pop     = i_baud && i_valid && (state == IDLE || last_stop);
    assign par_bit   = PARITY == int'(PAR_EVEN) ? ^word : ~^word;
    // The popped word is copied into shift/word so later FIFO writes cannot disturb the frame.
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            state    <= IDLE;
            o_tx     <= IDLE_LEVEL;
            o_busy   <= 1'b0;
            shift    <= '0;
            word     <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
        end else if (i_baud) begin
            case (state)
                IDLE, STOP:
                    if (o_pop) begin
                        state  <= START;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                        shift  <= i_data;
                        word   <= i_data;
                    end else if (state == STOP && !last_stop) stop_cnt <= stop_cnt + 1'b1;
                    else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                START: begin
                    state <= DATA;
                    o_tx  <= shift[0];
                    idx   <= '0;
                end
                DATA: begin
                    shift <= shift >> 1;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(DATA_W - 1)) begin
                        state    <= PARITY != 0 ? PAR : STOP;
                        o_tx     <= PARITY != 0 ? par_bit : IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                    end else o_tx <= shift[1];
                end
                PAR: begin
                    state    <= STOP;
                    o_tx     <= IDLE_LEVEL;
                    stop_cnt <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO feeding a UART serializer, with occupancy and overflow reporting.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wp, rp;
    logic              full, empty, wr_ok, pop;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign empty = wp == rp;
    assign wr_ok = bus.i_write && !full;
    assign bus.o_full  = full;
    assign bus.o_empty = empty;
    assign bus.o_count = wp - rp;
    always_ff @(posedge i_clk)
        if (wr_ok) mem[wp[AW-1:0]] <= bus.i_D;
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            wp             <= '0;
            rp             <= '0;
            bus.o_overflow <= 1'b0;
        end else begin
            wp             <= wp + (AW + 1)'(wr_ok);
            rp             <= rp + (AW + 1)'(pop);
            bus.o_overflow <= bus.i_write && full;
        end
    uart_tx_serializer #(
        .DATA_W   (DATA_W),
        .PARITY   (PARITY),
        .STOP_BITS(STOP_BITS)
    ) u_ser (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_baud (bus.i_baud),
        .i_valid(!empty),
        .i_data (mem[rp[AW-1:0]]),
        .o_pop  (pop),
        .o_busy (bus.o_busy),
        .o_tx   (bus.o_tx)
    );
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three configurations driven in parallel, checked against a queue-based frame model.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       baud = 1'b0;
    logic [7:0] d = '0;
    logic       chk_en = 1'b0;
    int         total = 0;
    int         passed = 0;
    logic [31:0] s_tx [3];
    logic [31:0] s_busy [3];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instance 0: no parity, 1 stop; 1: even parity, 2 stops; 2: odd parity, 1 stop.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PAR_G  = g == 0 ? 0 : (g == 1 ? 2 : 1);
        localparam int STOP_G = g == 1 ? 2 : 1;
        uart_tx_fifo_if #(.DATA_W(8), .DEPTH(8)) bus ();
        assign bus.i_D     = d;
        assign bus.i_write = wr;
        assign bus.i_baud  = baud;
        uart_tx_fifo #(.DATA_W(8), .DEPTH(8), .PARITY(PAR_G), .STOP_BITS(STOP_G)) dut (
            .i_clk(clk),
            .i_rst(rst_n),
            .bus  (bus)
        );
        logic [7:0] mq[$];
        bit         fr[$];
        bit         m_ovf = 1'b0;
        bit         m_full;
        logic [7:0] w;
        // Pending words wait in mq; the frame on the wire is a list of line levels, head first.
        always @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                mq.delete();
                fr.delete();
                m_ovf = 1'b0;
            end else begin
                m_full = mq.size() == 8;
                m_ovf  = wr && m_full;
                if (baud) begin
                    if (fr.size() != 0) void'(fr.pop_front());
                    if (fr.size() == 0 && mq.size() != 0) begin
                        w = mq.pop_front();
                        fr.push_back(1'b0);
                        for (int i = 0; i < 8; i++) fr.push_back(w[i]);
                        if (PAR_G != 0) fr.push_back(PAR_G == 2 ? ^w : ~^w);
                        for (int i = 0; i < STOP_G; i++) fr.push_back(1'b1);
                    end
                end
                if (wr && !m_full) mq.push_back(d);
            end
        always @(negedge clk)
            if (chk_en) begin
                check($sformatf("tx%0d", g), 32'(bus.o_tx), 32'(fr.size() != 0 ? fr[0] : 1'b1));
                check($sformatf("busy%0d", g), 32'(bus.o_busy), 32'(fr.size() != 0));
                check($sformatf("count%0d", g), 32'(bus.o_count), 32'(mq.size()));
                check($sformatf("full%0d", g), 32'(bus.o_full), 32'(mq.size() == 8));
                check($sformatf("empty%0d", g), 32'(bus.o_empty), 32'(mq.size() == 0));
                check($sformatf("ovf%0d", g), 32'(bus.o_overflow), 32'(m_ovf));
            end
    end

    task automatic put(input logic [7:0] v);
        d  = v;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // One baud tick per period of 'gap' cycles; records line and busy right after each tick.
    task automatic run_periods(input int n, input int gap);
        for (int i = 0; i < 3; i++) begin
            s_tx[i]   = '0;
            s_busy[i] = '0;
        end
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
            if (k < 32) begin
                s_tx[0][k]   = g_dut[0].bus.o_tx;
                s_tx[1][k]   = g_dut[1].bus.o_tx;
                s_tx[2][k]   = g_dut[2].bus.o_tx;
                s_busy[0][k] = g_dut[0].bus.o_busy;
                s_busy[1][k] = g_dut[1].bus.o_busy;
                s_busy[2][k] = g_dut[2].bus.o_busy;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(8'hA5);
        run_periods(14, 16);
        check("a5_frame", 32'(s_tx[0][10:0]), 32'h74A);
        check("a5_busy_periods", $countones(s_busy[0]), 10);
        check("a5_even_par", 32'(s_tx[1][9]), 0);
        check("a5_odd_par", 32'(s_tx[2][9]), 1);
        put(8'h07);
        run_periods(14, 16);
        check("07_even_par", 32'(s_tx[1][9]), 1);
        check("07_odd_par", 32'(s_tx[2][9]), 0);
        check("par_stop1_len", $countones(s_busy[2]), 11);
        check("par_stop2_len", $countones(s_busy[1]), 12);
        put(8'h3C);
        put(8'h81);
        run_periods(26, 3);
        check("b2b_stop1", 32'(s_tx[1][10]), 1);
        check("b2b_stop2", 32'(s_tx[1][11]), 1);
        check("b2b_start", 32'(s_tx[1][12]), 0);
        check("b2b_busy", 32'(s_busy[1][23:0]), 32'hFFFFFF);
        check("b2b_start_nopar", 32'(s_tx[0][10]), 0);
        for (int i = 1; i <= 8; i++) put(8'(i));
        d  = 8'hFF;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("fill_ovf", 32'(g_dut[0].bus.o_overflow), 1);
        check("fill_count", 32'(g_dut[0].bus.o_count), 8);
        check("fill_full", 32'(g_dut[0].bus.o_full), 1);
        @(negedge clk);
        check("ovf_single", 32'(g_dut[0].bus.o_overflow), 0);
        run_periods(110, 1);
        check("drain_empty", 32'(g_dut[1].bus.o_empty), 1);
        for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
        @(negedge clk);
        d    = 8'hEE;
        wr   = 1'b1;
        baud = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
        baud = 1'b0;
        check("pop_full_ovf", 32'(g_dut[0].bus.o_overflow), 1);
        check("pop_full_count", 32'(g_dut[0].bus.o_count), 7);
        run_periods(110, 1);
        for (int c = 0; c < 3000; c++) begin
            wr   = $urandom_range(0, 2) == 0;
            d    = 8'($urandom);
            baud = $urandom_range(0, 3) == 0;
            @(negedge clk);
        end
        wr   = 1'b0;
        baud = 1'b0;
        run_periods(120, 1);
        put(8'h52);
        @(negedge clk);
        run_periods(5, 1);
        check("rst_pre_tx", 32'(g_dut[0].bus.o_tx), 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(g_dut[0].bus.o_tx), 1);
        check("rst_empty", 32'(g_dut[0].bus.o_empty), 1);
        check("rst_busy", 32'(g_dut[0].bus.o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(8'hC3);
        run_periods(12, 4);
        check("post_rst_frame", 32'(s_tx[0][10:0]), 32'h786);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
